gs232c_ram_arbiter: RTL and testbench

Sequencer and arbiter for one single-port, 1-cycle-read RAM array, such as a cache tag/valid array. After reset or a flush it sweeps every entry and writes INIT_VAL. It then shares the RAM port between a write requester (refill) and a read requester (lookup). Fixed write priority applies, with a starvation guard for reads. It sits between the cache control logic and the RAM macro.

---
 rtl/gs232c_ram_arbiter.sv | 72 +++++++
 tb/tb_gs232c_ram_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gs232c_ram_arbiter.sv
// gs232c_ram_arbiter: init sweep plus write-priority arbiter with a read starvation guard for one single-port RAM
// Ports: clock/resetn (async active-low); flush_req restarts the sweep, init_busy flags it;
// wr_* / rd_* are held-until-ack requesters with combinational acks; rd_rvalid/rd_rdata return
// read data one cycle after rd_ack; ram_* drive a 1-cycle-read single-port RAM macro.
module gs232c_ram_arbiter #(
  parameter int                IDX_W    = 6,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush_req,
  output logic              init_busy,
  input  logic              wr_req,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_ack,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [IDX_W-1:0]  ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t            r_state, w_state_nx;
  logic [IDX_W-1:0]  r_idx, w_idx_nx;
  logic [3:0]        r_wait, w_wait_nx;
  logic              r_rvalid;
  logic              w_go, w_rd_win;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state  <= S_INIT;
      r_idx    <= '0;
      r_wait   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_wait   <= w_wait_nx;
      r_rvalid <= rd_ack;
    end
  // A flush cycle grants nothing; the read wins outright or once it has waited MAX_WAIT cycles.
  always_comb begin
    w_go       = resetn && r_state == S_RUN && !flush_req;
    w_rd_win   = rd_req && (!wr_req || r_wait == 4'(MAX_WAIT));
    rd_ack     = w_go && w_rd_win;
    wr_ack     = w_go && wr_req && !w_rd_win;
    init_busy  = r_state == S_INIT;
    ram_en     = resetn && (init_busy || wr_ack || rd_ack);
    ram_we     = resetn && (init_busy || wr_ack);
    ram_addr   = init_busy ? r_idx : wr_ack ? wr_idx : rd_idx;
    ram_wdata  = init_busy ? INIT_VAL : wr_data;
    w_state_nx = r_state;
    w_idx_nx   = '0;
    w_wait_nx  = '0;
    if (r_state == S_INIT) begin
      if (!flush_req && r_idx != '1) w_idx_nx = r_idx + IDX_W'(1);
      if (!flush_req && r_idx == '1) w_state_nx = S_RUN;
    end else if (flush_req)
      w_state_nx = S_INIT;
    else if (rd_req && !rd_ack)
      w_wait_nx = r_wait == 4'(MAX_WAIT) ? r_wait : r_wait + 4'd1;
  end
  assign rd_rvalid = r_rvalid;
  assign rd_rdata  = ram_rdata;
endmodule

// File: tb/tb_gs232c_ram_arbiter.sv
// tb_gs232c_ram_arbiter: vector table, directed corner sequences and random traffic against a behavioural model
module tb_gs232c_ram_arbiter;
  localparam int IW = 6, DW = 32, MW = 4, N = 64;
  logic          clock = 0, resetn = 0, flush_req = 0, wr_req = 0, rd_req = 0;
  logic [IW-1:0] wr_idx = 0, rd_idx = 0;
  logic [DW-1:0] wr_data = 0;
  logic          init_busy, wr_ack, rd_ack, rd_rvalid, ram_en, ram_we;
  logic [IW-1:0] ram_addr;
  logic [DW-1:0] rd_rdata, ram_wdata, ram_rdata;
  logic [DW-1:0] mem [N];

  gs232c_ram_arbiter #(.IDX_W(IW), .DATA_W(DW), .INIT_VAL('0), .MAX_WAIT(MW)) dut (
    .clock(clock), .resetn(resetn), .flush_req(flush_req), .init_busy(init_busy),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clock = ~clock;

  always @(posedge clock)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  // Behavioural model: sweeping flag, sweep position, denied-read count, RAM contents.
  bit            m_init = 1, m_rv = 0;
  int            m_idx = 0, m_wait = 0;
  logic [DW-1:0] m_rd_exp, shadow [N];
  bit            e_wack, e_rack, e_en, e_we;
  logic          s_busy, s_wack, s_rack, s_en, s_we, s_rv;
  logic [IW-1:0] s_addr;
  logic [DW-1:0] s_rdata;
  int            total = 0, bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (!resetn) begin m_init = 1; m_idx = 0; m_wait = 0; m_rv = 0; end
    e_rack = resetn && !m_init && !flush_req && rd_req && (!wr_req || m_wait == MW);
    e_wack = resetn && !m_init && !flush_req && wr_req && !e_rack;
    e_en   = resetn && (m_init || e_wack || e_rack);
    e_we   = resetn && (m_init || e_wack);
    s_busy = init_busy; s_wack = wr_ack; s_rack = rd_ack; s_en = ram_en; s_we = ram_we;
    s_rv = rd_rvalid; s_addr = ram_addr; s_rdata = rd_rdata;
    chk("busy", init_busy, m_init);
    chk("wr_ack", wr_ack, e_wack);
    chk("rd_ack", rd_ack, e_rack);
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    if (e_en) chk("ram_addr", ram_addr, m_init ? IW'(m_idx) : e_wack ? wr_idx : rd_idx);
    if (e_we) chk("ram_wdata", ram_wdata, m_init ? '0 : wr_data);
    chk("rd_rvalid", rd_rvalid, m_rv);
    if (m_rv) chk("rd_rdata", rd_rdata, m_rd_exp);
    @(posedge clock);
    if (resetn) begin
      m_rv = e_rack;
      if (e_rack) m_rd_exp = shadow[rd_idx];
      if (m_init) begin
        shadow[m_idx] = '0;
        if (flush_req) m_idx = 0;
        else if (m_idx == N - 1) begin m_init = 0; m_idx = 0; end
        else m_idx++;
      end else if (flush_req) begin
        m_init = 1; m_idx = 0; m_wait = 0;
      end else begin
        if (e_wack) shadow[wr_idx] = wr_data;
        m_wait = (rd_req && !e_rack) ? (m_wait < MW ? m_wait + 1 : MW) : 0;
      end
    end
    #1;
  endtask

  typedef struct {
    bit fl, wr, rd; logic [IW-1:0] wi, ri; logic [DW-1:0] wd;
    bit wack, rack, en, we; logic [IW-1:0] addr; bit rv; logic [DW-1:0] rdat;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,       0,0,0,0,0, 0,0};
    tbl[1]  = '{0,1,0,3,0,'h33,    1,0,1,1,3, 0,0};
    tbl[2]  = '{0,1,1,5,5,'h55,    1,0,1,1,5, 0,0};
    tbl[3]  = '{0,0,1,0,5,0,       0,1,1,0,5, 0,0};
    tbl[4]  = '{0,1,1,9,7,'h99,    1,0,1,1,9, 1,'h55};
    tbl[5]  = '{0,1,1,9,7,'h99,    1,0,1,1,9, 0,0};
    tbl[6]  = '{0,1,1,9,7,'h99,    1,0,1,1,9, 0,0};
    tbl[7]  = '{0,1,1,9,7,'h99,    1,0,1,1,9, 0,0};
    tbl[8]  = '{0,1,1,9,7,'h99,    0,1,1,0,7, 0,0};
    tbl[9]  = '{0,1,0,9,0,'h99,    1,0,1,1,9, 1,0};
    tbl[10] = '{1,1,1,9,7,'h99,    0,0,0,0,0, 0,0};

    repeat (2) @(posedge clock);
    #1;
    step();
    chk("reset_en", s_en, 0);
    resetn = 1;
    for (int i = 0; i < N; i++) begin
      step();
      chk("sweep_addr", s_addr, i);
      chk("sweep_busy", s_busy, 1);
    end
    step();
    chk("post_sweep_en", s_en, 0);
    chk("post_sweep_busy", s_busy, 0);

    flush_req = 1;
    step();
    flush_req = 0;
    wr_req = 1; wr_idx = 12; wr_data = 'hC0FFEE;
    for (int i = 0; i < N; i++) begin
      step();
      chk("held_wr_no_ack", s_wack, 0);
    end
    step();
    chk("first_run_wack", s_wack, 1);
    chk("first_run_addr", s_addr, 12);
    wr_req = 0;

    for (int r = 0; r < 11; r++) begin
      flush_req = tbl[r].fl; wr_req = tbl[r].wr; rd_req = tbl[r].rd;
      wr_idx = tbl[r].wi; rd_idx = tbl[r].ri; wr_data = tbl[r].wd;
      step();
      chk($sformatf("vec%0d_wack", r), s_wack, tbl[r].wack);
      chk($sformatf("vec%0d_rack", r), s_rack, tbl[r].rack);
      chk($sformatf("vec%0d_en", r), s_en, tbl[r].en);
      chk($sformatf("vec%0d_we", r), s_we, tbl[r].we);
      if (tbl[r].en) chk($sformatf("vec%0d_addr", r), s_addr, tbl[r].addr);
      chk($sformatf("vec%0d_rv", r), s_rv, tbl[r].rv);
      if (tbl[r].rv) chk($sformatf("vec%0d_rdata", r), s_rdata, tbl[r].rdat);
    end
    flush_req = 0; wr_req = 0; rd_req = 0;

    repeat (30) step();
    flush_req = 1;
    step();
    chk("flush30_addr", s_addr, 30);
    flush_req = 0;
    for (int i = 0; i < N; i++) begin
      step();
      chk("resweep_addr", s_addr, i);
      chk("resweep_busy", s_busy, 1);
    end
    step();
    chk("resweep_done", s_busy, 0);

    rd_req = 1; rd_idx = 2;
    step();
    chk("pre_flush_rack", s_rack, 1);
    rd_req = 0; flush_req = 1;
    step();
    chk("flush_rvalid", s_rv, 1);
    chk("flush_en", s_en, 0);
    flush_req = 0;
    repeat (40) step();
    resetn = 0; wr_req = 1; wr_idx = 4; wr_data = 'h44;
    step();
    chk("rst40_en", s_en, 0);
    chk("rst40_wack", s_wack, 0);
    resetn = 1;
    step();
    chk("rst40_restart", s_addr, 0);
    repeat (N - 1) step();
    step();
    chk("run_wack", s_wack, 1);
    resetn = 0;
    step();
    chk("rst_run_en", s_en, 0);
    chk("rst_run_wack", s_wack, 0);
    resetn = 1; wr_req = 0;
    step();
    chk("rst_run_restart", s_addr, 0);
    chk("rst_run_busy", s_busy, 1);

    for (int c = 0; c < 4000; c++) begin
      if (!wr_req || s_wack) begin
        wr_req  = $urandom_range(0, 2) != 0;
        wr_idx  = ($urandom_range(0, 3) == 0) ? IW'($urandom) : IW'($urandom_range(0, 7));
        wr_data = $urandom;
      end
      if (!rd_req || s_rack) begin
        rd_req = $urandom_range(0, 1) != 0;
        rd_idx = ($urandom_range(0, 3) == 0) ? IW'($urandom) : IW'($urandom_range(0, 7));
      end
      flush_req = $urandom_range(0, 149) == 0;
      resetn    = $urandom_range(0, 399) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
